// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO and its write-side arbiter.
package async_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int ARB_MAX_REQ     = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      start,
  output logic [IW-1:0]      idx,
  output logic               found
);

  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = (pos == LAST) ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing the async FIFO write port among wclk producers.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = $clog2(NUM_REQ),
  localparam int BW         = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IW-1:0]                 owner,
  output logic                          busy
);

  localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_e            state, state_nxt;
  logic [IW-1:0]         owner_nxt, last_owner, last_owner_nxt;
  logic [IW-1:0]         pick_base, pick_start, pick_idx;
  logic                  pick_found;
  logic [BW-1:0]         beat_cnt, beat_nxt;
  logic                  owner_valid, accept, rel;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Searching from owner+1 during a burst leaves the releasing owner last, so it is only re-granted when alone.
  always_comb begin
    pick_base  = (state == ARB_BURST) ? owner : last_owner;
    pick_start = (pick_base == LAST) ? '0 : pick_base + 1'b1;
  end

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .start(pick_start),
    .idx  (pick_idx),
    .found(pick_found)
  );

  // Everything visible to the FIFO and producers is gated off while reset is held.
  always_comb begin
    busy        = wrst_n && (state == ARB_BURST);
    owner_valid = req_valid[owner];
    accept      = busy && owner_valid && !wfull;
    winc        = accept;
    wdata       = accept ? words[owner] : '0;
    req_ready   = '0;
    if (busy && !wfull) begin
      req_ready[owner] = 1'b1;
    end
    rel = busy && ((accept && (beat_cnt == LAST_BEAT)) || (!owner_valid && !wfull));
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    beat_nxt       = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_nxt = ARB_BURST;
          owner_nxt = pick_idx;
          beat_nxt  = '0;
        end
      end
      ARB_BURST: begin
        if (rel) begin
          last_owner_nxt = owner;
          beat_nxt       = '0;
          if (pick_found) begin
            owner_nxt = pick_idx;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (accept) begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= LAST;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      beat_cnt   <= beat_nxt;
      last_owner <= last_owner_nxt;
    end
  end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: 4 requesters, 8-bit words, bursts of 4.
module tb_async_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [1:0]  owner;
  logic        busy;

  logic [7:0]  base [4];
  logic [7:0]  cnt  [4];
  logic [3:0]  pend;
  logic [31:0] hist;
  int          ncyc;
  logic [7:0]  wlog [$];
  logic [1:0]  olog [$];
  int          total;
  int          bad;

  async_fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .owner    (owner),
    .busy     (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Each producer presents base+count and advances count only after an accepting edge.
  assign req_data = {base[3] + cnt[3], base[2] + cnt[2], base[1] + cnt[1], base[0] + cnt[0]};

  task automatic cyc(input logic rst_n_i, input logic [3:0] v, input logic f);
    @(negedge wclk);
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) cnt[i] = cnt[i] + 8'd1;
    end
    wrst_n    = rst_n_i;
    req_valid = v;
    wfull     = f;
    #1;
    pend       = req_valid & req_ready;
    hist[ncyc] = winc;
    if (winc) begin
      wlog.push_back(wdata);
      olog.push_back(owner);
    end
    ncyc++;
  endtask

  task automatic start_test(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    cyc(1'b0, 4'b0000, 1'b0);
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    for (int i = 0; i < 4; i++) cnt[i] = 8'd0;
    pend = 4'b0000;
    hist = 32'd0;
    ncyc = 0;
    wlog.delete();
    olog.delete();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 4'b1111, 1'b0);
      total++;
      if (winc !== 1'b0) begin bad++; $display("[TB] FAIL reset_winc cyc=%0d got=%b want=0", k, winc); end
      total++;
      if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready cyc=%0d got=%b want=0000", k, req_ready); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy cyc=%0d got=%b want=0", k, busy); end
      total++;
      if (wdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_wdata cyc=%0d got=%h want=00", k, wdata); end
    end
  endtask

  task automatic test_single();
    int sent;
    start_test(8'h00, 8'h00, 8'h11, 8'h00);
    for (int k = 0; k < 8; k++) begin
      sent = int'(cnt[2]) + int'(pend[2]);
      cyc(1'b1, (sent < 6) ? 4'b0100 : 4'b0000, 1'b0);
      if (k == 0) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_grant_latency got busy=%b want=0", busy); end
      end
    end
    total++;
    if (hist[7:0] !== 8'b0111_1110) begin bad++; $display("[TB] FAIL single_winc_pattern got=%b want=01111110", hist[7:0]); end
    total++;
    if (wlog.size() != 6) begin bad++; $display("[TB] FAIL single_count got=%0d want=6", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 6; k++) begin
      total++;
      if (wlog[k] !== 8'(8'h11 + k) || olog[k] !== 2'd2) begin
        bad++;
        $display("[TB] FAIL single_word[%0d] got=%h/own%0d want=%h/own2", k, wlog[k], olog[k], 8'(8'h11 + k));
      end
    end
  endtask

  task automatic test_fairness();
    int own;
    int c;
    start_test(8'h00, 8'h40, 8'h80, 8'hC0);
    for (int k = 0; k < 21; k++) begin
      cyc(1'b1, 4'b1111, 1'b0);
      total++;
      if ($countones(req_ready) > 1) begin bad++; $display("[TB] FAIL fair_onehot cyc=%0d got=%b want<=1 bit", k, req_ready); end
    end
    total++;
    if (hist[20:0] !== 21'h1FFFFE) begin bad++; $display("[TB] FAIL fair_winc_pattern got=%h want=1ffffe", hist[20:0]); end
    total++;
    if (wlog.size() != 20) begin bad++; $display("[TB] FAIL fair_count got=%0d want=20", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 20; k++) begin
      own = (k / 4) % 4;
      c   = (k / 16) * 4 + (k % 4);
      total++;
      if (olog[k] !== 2'(own) || wlog[k] !== 8'(own * 64 + c)) begin
        bad++;
        $display("[TB] FAIL fair_word[%0d] got=%h/own%0d want=%h/own%0d", k, wlog[k], olog[k], 8'(own * 64 + c), own);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic f;
    start_test(8'h00, 8'hA0, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      f = (k >= 3 && k <= 5);
      cyc(1'b1, (k <= 7) ? 4'b0010 : 4'b0000, f);
      if (f) begin
        total++;
        if (winc !== 1'b0 || req_ready !== 4'b0000) begin
          bad++;
          $display("[TB] FAIL bp_stall cyc=%0d got winc=%b ready=%b want 0/0000", k, winc, req_ready);
        end
        total++;
        if (owner !== 2'd1 || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL bp_hold cyc=%0d got owner=%0d busy=%b want 1/1", k, owner, busy);
        end
      end
    end
    total++;
    if (hist[8:0] !== 9'b0_1100_0110) begin bad++; $display("[TB] FAIL bp_winc_pattern got=%b want=011000110", hist[8:0]); end
    total++;
    if (wlog.size() != 4) begin bad++; $display("[TB] FAIL bp_count got=%0d want=4", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 4; k++) begin
      total++;
      if (wlog[k] !== 8'(8'hA0 + k)) begin bad++; $display("[TB] FAIL bp_word[%0d] got=%h want=%h", k, wlog[k], 8'(8'hA0 + k)); end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] v;
    logic [7:0] exp_w [7];
    logic [1:0] exp_o [9];
    exp_w = '{8'h30, 8'h31, 8'h00, 8'h01, 8'h02, 8'h03, 8'h10};
    exp_o = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    start_test(8'h00, 8'h10, 8'h00, 8'h30);
    for (int k = 0; k < 9; k++) begin
      v = (k <= 2) ? 4'b1000 : ((k == 3) ? 4'b0001 : 4'b0011);
      cyc(1'b1, v, 1'b0);
      if (k >= 3) begin
        total++;
        if (owner !== exp_o[k] || busy !== 1'b1) begin
          bad++;
          $display("[TB] FAIL early_owner cyc=%0d got owner=%0d busy=%b want %0d/1", k, owner, busy, exp_o[k]);
        end
      end
    end
    total++;
    if (hist[8:0] !== 9'b1_1111_0110) begin bad++; $display("[TB] FAIL early_winc_pattern got=%b want=111110110", hist[8:0]); end
    total++;
    if (wlog.size() != 7) begin bad++; $display("[TB] FAIL early_count got=%0d want=7", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 7; k++) begin
      total++;
      if (wlog[k] !== exp_w[k]) begin bad++; $display("[TB] FAIL early_word[%0d] got=%h want=%h", k, wlog[k], exp_w[k]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] exp_w [3];
    exp_w = '{8'h50, 8'h51, 8'h60};
    start_test(8'h60, 8'h50, 8'h00, 8'h00);
    for (int k = 0; k < 6; k++) begin
      cyc((k == 3) ? 1'b0 : 1'b1, (k <= 2) ? 4'b0010 : 4'b0011, 1'b0);
      if (k == 3) begin
        total++;
        if (winc !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
          bad++;
          $display("[TB] FAIL rst_mid_gate got winc=%b busy=%b ready=%b want 0/0/0000", winc, busy, req_ready);
        end
      end else if (k == 4) begin
        total++;
        if (winc !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rst_mid_idle got winc=%b busy=%b want 0/0", winc, busy);
        end
      end else if (k == 5) begin
        total++;
        if (owner !== 2'd0 || winc !== 1'b1 || wdata !== 8'h60) begin
          bad++;
          $display("[TB] FAIL rst_mid_regrant got owner=%0d winc=%b wdata=%h want 0/1/60", owner, winc, wdata);
        end
      end
    end
    total++;
    if (hist[5:0] !== 6'b10_0110) begin bad++; $display("[TB] FAIL rst_mid_winc_pattern got=%b want=100110", hist[5:0]); end
    total++;
    if (wlog.size() != 3) begin bad++; $display("[TB] FAIL rst_mid_count got=%0d want=3", wlog.size()); end
    for (int k = 0; k < wlog.size() && k < 3; k++) begin
      total++;
      if (wlog[k] !== exp_w[k]) begin bad++; $display("[TB] FAIL rst_mid_word[%0d] got=%h want=%h", k, wlog[k], exp_w[k]); end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    wrst_n    = 1'b0;
    req_valid = 4'b0000;
    wfull     = 1'b0;
    pend      = 4'b0000;
    hist      = 32'd0;
    ncyc      = 0;
    for (int i = 0; i < 4; i++) begin
      base[i] = 8'd0;
      cnt[i]  = 8'd0;
    end
    $display("[TB] start");
    test_reset();
    test_single();
    test_fairness();
    test_back_pressure();
    test_early_release();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
